ycrcb_to_rgb: RTL
=================

Name: ycrcb_to_rgb

Overview:
- Pipelined YCrCb→RGB colour-space converter; inverse of the camera-side RGB→YCrCb stage.
- Sits after the vision processing (thresholding/overlay) and before the display/VGA writer, returning pixels to 8-bit RGB.
- Streaming valid/ready on both sides; a user sideband (sof/eol flags) travels in lockstep with each pixel.

Parameters:
USER_W, 2, width of sideband bits carried unchanged with each pixel (e.g. {eol, sof})

Ports:
clk  in  1  system clock; all logic rising-edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept input this cycle
in_y  in  8  luma, unsigned
in_cr  in  8  Cr, unsigned, offset 128
in_cb  in  8  Cb, unsigned, offset 128
in_user  in  USER_W  sideband, passed through
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts output
out_r  out  8  red, unsigned
out_g  out  8  green, unsigned
out_b  out  8  blue, unsigned
out_user  out  USER_W  sideband aligned with out_r/g/b

Behaviour:
- Transfer happens when valid && ready, on either interface; on each side, a transfer is the only event that consumes or produces a pixel.
- Arithmetic is Q8 fixed point:
  - R = Y + 1.403·dCr
  - G = Y − 0.344·dCb − 0.714·dCr
  - B = Y + 1.773·dCb
  - dCr = Cr−128 and dCb = Cb−128, both 9-bit signed.
  - Constants: K_R_CR=359, K_G_CB=88, K_G_CR=183, K_B_CB=454, each 10-bit signed positive.
- Pipeline, three register stages, each with its own valid bit v1..v3:
  - S1: register Y, dCr, dCb and user.
  - S2: register the four products, 19-bit signed each, plus Y and user.
  - S3: compute sum = (Y<<8) ± products + 128 in 21-bit signed; arithmetic shift right by 8 (round-half-up); saturate to 0..255; register into out_*.
- Stall (bubble-collapsing):
  - en3 = !v3 || out_ready
  - en2 = !v2 || en3
  - en1 = !v1 || en2
  - in_ready = en1 (combinational from out_ready and the valid bits; no path from in_valid).
  - When stage k is enabled: vk <= v(k−1) and data advances; the input side counts as v0 = in_valid.
  - Stage data registers may load don't-care when the incoming valid is 0; valid bits must be exact.
- out_valid = v3. out_r/g/b/user hold stable while out_valid && !out_ready.
- Latency: 3 cycles from input transfer to out_valid with out_ready held high. Sustained throughput is 1 pixel/clk.
- Reset: v1..v3 <= 0. out_r/g/b <= 0, out_user <= 0, out_valid = 0. in_ready is 1 during the cycle after reset is released. Reset mid-stream discards all in-flight pixels; no partial output is emitted.
- Boundary conditions:
  - Saturation applies independently per channel. Negative sums give 0; sums ≥ 256 give 255.
  - With the pipeline full and out_ready=0, in_ready=0. When out_ready rises, in_ready rises in the same cycle, and input and output transfer together.
  - Bubbles in in_valid propagate as bubbles and never duplicate a pixel.
  - sof/eol bits are never altered or reordered relative to their pixel.

Decomposition:
- Shared package ycrcb_pkg holds:
  - Q8 coefficient constants (K_R_CR, K_G_CB, K_G_CR, K_B_CB, plus the forward Y/Cr/Cb constants)
  - CHROMA_OFFSET=128, FRAC_BITS=8
  - a pixel struct/typedef {y, cr, cb}
  - a function sat_u8 (signed → clamped 8-bit)
- One natural sub-module: sat_round_u8. It does rounding add, shift and clamp, one instance per channel in S3.

Test Plan:
- Grey: Y=128, Cr=128, Cb=128, user=01 → R/G/B=128/128/128, out_user=01, out_valid exactly 3 cycles after the transfer.
- Clamp: Y=0, Cr=0, Cb=0 → R=0, G=136, B=0. Y=255, Cr=255, Cb=128 → R=255, G=164, B=255.
- Mixed chroma: Y=100, Cr=128, Cb=200 → R=100, G=75, B=228.
- Backpressure:
  - Stream 10 pixels with out_ready=0 → in_ready drops after 3 accepted; outputs stay stable.
  - Release out_ready → all 10 pixels emerge in order with no loss or duplication, checked against a reference model.
- Throughput: in_valid and out_ready held high for 256 random pixels → one output per cycle after 3-cycle fill; every output matches the Q8 model bit-exactly.
- Reset mid-stream: assert rst with 3 pixels in flight → next cycle out_valid=0 and outputs=0; the pixels are never emitted; a fresh pixel after reset yields correct output at latency 3.

Source files
------------

// File: rtl/ycrcb_pkg.sv
// ycrcb_pkg: shared definitions for the YCrCb <-> RGB colour-space stages.
//   - Q8 coefficients for the inverse (display-side) and forward (camera-side)
//     transforms
//   - chroma offset and fixed-point fraction width
//   - pixel_t : packed {y, cr, cb} triple
//   - sat_u8  : clamp a signed integer-part value to an unsigned 8-bit pixel
package ycrcb_pkg;

  localparam int FRAC_BITS     = 8;
  localparam int CHROMA_OFFSET = 128;

  // Datapath widths: 9-bit signed chroma delta x 10-bit signed coefficient,
  // and the Q8 accumulator that holds (Y<<8) plus/minus the products.
  localparam int DELTA_W = 9;
  localparam int COEF_W  = 10;
  localparam int PROD_W  = 19;
  localparam int SUM_W   = 21;
  localparam int INT_W   = SUM_W - FRAC_BITS;

  // Inverse transform, Q8 (x256).
  localparam logic signed [COEF_W-1:0] K_R_CR = 10'sd359;  // 1.403
  localparam logic signed [COEF_W-1:0] K_G_CB = 10'sd88;   // 0.344
  localparam logic signed [COEF_W-1:0] K_G_CR = 10'sd183;  // 0.714
  localparam logic signed [COEF_W-1:0] K_B_CB = 10'sd454;  // 1.773

  // Forward transform used by the camera-side stage, Q8, kept here so both
  // directions share one source of truth.
  localparam logic signed [COEF_W-1:0] K_Y_R  = 10'sd77;   // 0.299
  localparam logic signed [COEF_W-1:0] K_Y_G  = 10'sd150;  // 0.587
  localparam logic signed [COEF_W-1:0] K_Y_B  = 10'sd29;   // 0.114
  localparam logic signed [COEF_W-1:0] K_CR_F = 10'sd183;  // 0.713 * (R-Y)
  localparam logic signed [COEF_W-1:0] K_CB_F = 10'sd144;  // 0.564 * (B-Y)

  // Half an LSB of the integer result, added before the shift so that the
  // arithmetic shift rounds half-up instead of truncating toward -inf.
  localparam logic signed [SUM_W-1:0] ROUND_HALF = 21'sd128;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cr;
    logic [7:0] cb;
  } pixel_t;

  function automatic logic [7:0] sat_u8(input logic signed [INT_W-1:0] v);
    logic [7:0] res;
    if (v < 0) begin
      res = 8'd0;
    end else if (v > 13'sd255) begin
      res = 8'd255;
    end else begin
      res = v[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/ycrcb_to_rgb_sat_round_u8.sv
// sat_round_u8: converts one Q8 channel accumulator to an 8-bit pixel.
//   i_sum : signed Q8 sum (Y<<8 plus/minus chroma products), SUM_W bits
//   o_pix : round-half-up, arithmetic shift by FRAC_BITS, clamped to 0..255
module sat_round_u8
  import ycrcb_pkg::*;
(
  input  logic signed [SUM_W-1:0] i_sum,
  output logic        [7:0]       o_pix
);

  logic signed [SUM_W-1:0] w_rounded;

  // Headroom: |sum| stays below 2^17, so adding the half-LSB cannot wrap.
  assign w_rounded = i_sum + ROUND_HALF;

  // Taking the upper bits of a signed value is an arithmetic shift right.
  assign o_pix = sat_u8($signed(w_rounded[SUM_W-1:FRAC_BITS]));

endmodule

// File: rtl/ycrcb_to_rgb.sv
// ycrcb_to_rgb: three-stage pipelined YCrCb -> 8-bit RGB converter with
// valid/ready on both sides and a sideband that travels with each pixel.
//   clk, rst                        : clock, synchronous active-high reset
//   in_valid/in_ready               : input handshake (in_ready has no path
//                                     from in_valid)
//   in_y, in_cr, in_cb, in_user     : input pixel (chroma offset 128) + sideband
//   out_valid/out_ready             : output handshake
//   out_r, out_g, out_b, out_user   : output pixel + sideband, held while stalled
// Stages: S1 registers Y/dCr/dCb, S2 registers the four products, S3 sums,
// rounds and saturates into the output registers. Each stage has its own
// valid bit and advances whenever its downstream slot is empty or moving,
// so bubbles collapse under backpressure.
module ycrcb_to_rgb
  import ycrcb_pkg::*;
#(
  parameter int USER_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_y,
  input  logic [7:0]        in_cr,
  input  logic [7:0]        in_cb,
  input  logic [USER_W-1:0] in_user,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_r,
  output logic [7:0]        out_g,
  output logic [7:0]        out_b,
  output logic [USER_W-1:0] out_user
);

  // Stage valid bits.
  logic r_v1, r_v2, r_v3;

  // S1 data.
  pixel_t                    r_pix1;
  logic signed [DELTA_W-1:0] r_dcr1, r_dcb1;
  logic [USER_W-1:0]         r_user1;

  // S2 data.
  logic signed [PROD_W-1:0]  r_p_r_cr2, r_p_g_cb2, r_p_g_cr2, r_p_b_cb2;
  logic [7:0]                r_y2;
  logic [USER_W-1:0]         r_user2;

  // Stage enables: a stage may load when it is empty or its content leaves.
  logic w_en1, w_en2, w_en3;

  assign w_en3    = !r_v3 || out_ready;
  assign w_en2    = !r_v2 || w_en3;
  assign w_en1    = !r_v1 || w_en2;
  assign in_ready = w_en1;
  assign out_valid = r_v3;

  // Chroma deltas: range -128..127 fits the 9-bit signed result.
  logic signed [DELTA_W-1:0] w_dcr, w_dcb;
  assign w_dcr = $signed({1'b0, in_cr}) - 9'sd128;
  assign w_dcb = $signed({1'b0, in_cb}) - 9'sd128;

  // Products, operands sign-extended to the product width first.
  logic signed [PROD_W-1:0] w_p_r_cr, w_p_g_cb, w_p_g_cr, w_p_b_cb;
  assign w_p_r_cr = PROD_W'(r_dcr1) * PROD_W'(K_R_CR);
  assign w_p_g_cb = PROD_W'(r_dcb1) * PROD_W'(K_G_CB);
  assign w_p_g_cr = PROD_W'(r_dcr1) * PROD_W'(K_G_CR);
  assign w_p_b_cb = PROD_W'(r_dcb1) * PROD_W'(K_B_CB);

  // S3 accumulators in Q8.
  logic signed [SUM_W-1:0] w_y_q8, w_sum_r, w_sum_g, w_sum_b;
  assign w_y_q8  = $signed({{(SUM_W-16){1'b0}}, r_y2, 8'd0});
  assign w_sum_r = w_y_q8 + SUM_W'(r_p_r_cr2);
  assign w_sum_g = w_y_q8 - SUM_W'(r_p_g_cb2) - SUM_W'(r_p_g_cr2);
  assign w_sum_b = w_y_q8 + SUM_W'(r_p_b_cb2);

  logic [7:0] w_r, w_g, w_b;

  sat_round_u8 u_sat_r (.i_sum(w_sum_r), .o_pix(w_r));
  sat_round_u8 u_sat_g (.i_sum(w_sum_g), .o_pix(w_g));
  sat_round_u8 u_sat_b (.i_sum(w_sum_b), .o_pix(w_b));

  // Control and output registers: these are observable, so they are reset.
  // NOTE: state registers use non-blocking (<=) so every stage samples the
  // pre-edge value of its upstream neighbour; blocking here would let a
  // pixel fall through several stages in one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      out_r    <= 8'd0;
      out_g    <= 8'd0;
      out_b    <= 8'd0;
      out_user <= '0;
    end else begin
      if (w_en1) r_v1 <= in_valid;
      if (w_en2) r_v2 <= r_v1;
      if (w_en3) r_v3 <= r_v2;
      // Only load a real pixel, so idle outputs keep their last value.
      if (w_en3 && r_v2) begin
        out_r    <= w_r;
        out_g    <= w_g;
        out_b    <= w_b;
        out_user <= r_user2;
      end
    end
  end

  // Pipeline data registers.
  // NOTE: no reset on S1/S2 data -- their content is only ever consumed
  // when the matching valid bit is set, and the valid bits are reset.
  always_ff @(posedge clk) begin
    if (w_en1 && in_valid) begin
      r_pix1  <= '{y: in_y, cr: in_cr, cb: in_cb};
      r_dcr1  <= w_dcr;
      r_dcb1  <= w_dcb;
      r_user1 <= in_user;
    end
    if (w_en2 && r_v1) begin
      r_p_r_cr2 <= w_p_r_cr;
      r_p_g_cb2 <= w_p_g_cb;
      r_p_g_cr2 <= w_p_g_cr;
      r_p_b_cb2 <= w_p_b_cb;
      r_y2      <= r_pix1.y;
      r_user2   <= r_user1;
    end
  end

endmodule
